rom_rd_arbiter: RTL and testbench



---
 rtl/rom_rd_arbiter.sv | 98 +++++++++
 tb/tb_rom_rd_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rom_rd_arbiter.sv
// Two-requester read arbiter in front of a single-port ROM, with a latency pipe that routes rom_q back to the winner.
// Define ROM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); the default is round robin.
module rom_rd_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  output logic              gnt0,
  output logic              rvalid0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic              busy
);

  logic              hs;
  logic [ADDR_W-1:0] held_addr;
  logic [RD_LAT-1:0] pipe_valid;
  logic [RD_LAT-1:0] pipe_id;

`ifndef ROM_ARB_FIXED_PRIO_EN
  // Set when requester 1 won the most recent handshake, so requester 0 wins the next tie.
  logic last_gnt;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)
      last_gnt <= 1'b1;
    else if (hs)
      last_gnt <= gnt1;
  end
`endif

  // Grants are forced low while reset is asserted.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!sys_rst) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
      gnt0 = req0;
      gnt1 = req1 & ~req0;
`else
      if (req0 && req1) begin
        gnt0 = last_gnt;
        gnt1 = ~last_gnt;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
`endif
    end
  end

  assign hs = gnt0 | gnt1;

  always_comb begin
    rom_addr = held_addr;
    if (gnt0)
      rom_addr = addr0;
    else if (gnt1)
      rom_addr = addr1;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)
      held_addr <= '0;
    else if (hs)
      held_addr <= rom_addr;
  end

  // Each stage carries {valid, id}; the last stage lines up with rom_q for that read.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pipe_valid <= '0;
      pipe_id    <= '0;
    end else begin
      pipe_valid[0] <= hs;
      pipe_id[0]    <= gnt1;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_id[i]    <= pipe_id[i-1];
      end
    end
  end

  assign rvalid0 = pipe_valid[RD_LAT-1] & ~pipe_id[RD_LAT-1];
  assign rvalid1 = pipe_valid[RD_LAT-1] &  pipe_id[RD_LAT-1];
  assign busy    = |pipe_valid;
  assign rdata   = rom_q;

endmodule

// File: tb/tb_rom_rd_arbiter.sv
// Directed bench for rom_rd_arbiter: one instance with RD_LAT=1 (suffix _a), one with RD_LAT=2 (suffix _b).
// Both instances share the same request stimulus; each has its own ROM model with the matching latency.
module tb_rom_rd_arbiter;

`ifdef ROM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic       req0, req1;
  logic [7:0] addr0, addr1;

  logic       gnt0_a, gnt1_a, rvalid0_a, rvalid1_a, busy_a;
  logic [7:0] rdata_a, rom_addr_a, rom_q_a;
  logic       gnt0_b, gnt1_b, rvalid0_b, rvalid1_b, busy_b;
  logic [7:0] rdata_b, rom_addr_b, rom_q_b, rom_stage_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 sys_clk = ~sys_clk;

  rom_rd_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1)) u_dut_a (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .req0(req0), .addr0(addr0), .gnt0(gnt0_a), .rvalid0(rvalid0_a),
    .req1(req1), .addr1(addr1), .gnt1(gnt1_a), .rvalid1(rvalid1_a),
    .rdata(rdata_a), .rom_addr(rom_addr_a), .rom_q(rom_q_a), .busy(busy_a)
  );

  rom_rd_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(2)) u_dut_b (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .req0(req0), .addr0(addr0), .gnt0(gnt0_b), .rvalid0(rvalid0_b),
    .req1(req1), .addr1(addr1), .gnt1(gnt1_b), .rvalid1(rvalid1_b),
    .rdata(rdata_b), .rom_addr(rom_addr_b), .rom_q(rom_q_b), .busy(busy_b)
  );

  function automatic logic [7:0] rom_fn(input logic [7:0] a);
    return a ^ 8'hA5;
  endfunction

  // ROM models: registered address only (latency 1) and address + output register (latency 2).
  always @(posedge sys_clk) begin
    rom_q_a     <= rom_fn(rom_addr_a);
    rom_stage_b <= rom_fn(rom_addr_b);
    rom_q_b     <= rom_stage_b;
  end

  task automatic apply_stimulus(input logic r0, input logic [7:0] a0,
                                input logic r1, input logic [7:0] a1);
    @(negedge sys_clk);
    req0  = r0;
    addr0 = a0;
    req1  = r1;
    addr1 = a1;
    #1;
  endtask

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] t3_addr(input bit id);
    return id ? 8'h20 : 8'h10;
  endfunction

  initial begin
    bit ids[6];

    sys_rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; addr0 = 8'h00; addr1 = 8'h00;

    // Reset state, and grants forced low even with requests pending.
    @(negedge sys_clk);
    #1;
    check_output("rst_gnt0_a",   gnt0_a,     8'h0);
    check_output("rst_gnt1_a",   gnt1_a,     8'h0);
    check_output("rst_rvalid0_a", rvalid0_a, 8'h0);
    check_output("rst_rvalid1_a", rvalid1_a, 8'h0);
    check_output("rst_rom_addr_a", rom_addr_a, 8'h00);
    check_output("rst_busy_a",   busy_a,     8'h0);
    check_output("rst_rom_addr_b", rom_addr_b, 8'h00);
    check_output("rst_busy_b",   busy_b,     8'h0);
    req0 = 1'b1; req1 = 1'b1;
    #1;
    check_output("rst_forced_gnt0", gnt0_a, 8'h0);
    check_output("rst_forced_gnt1", gnt1_a, 8'h0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    $display("[TB] reset checks done");

    // Both requesters held: alternating grants starting with requester 0.
    for (int i = 0; i < 6; i++) begin
      ids[i] = FIXED ? 1'b0 : bit'(i % 2);
      apply_stimulus(1'b1, 8'h10, 1'b1, 8'h20);
      check_output("rr_gnt0_a", gnt0_a, {7'b0, ~ids[i]});
      check_output("rr_gnt1_a", gnt1_a, {7'b0, ids[i]});
      check_output("rr_gnt0_b", gnt0_b, {7'b0, ~ids[i]});
      check_output("rr_rom_addr_a", rom_addr_a, t3_addr(ids[i]));
      if (i == 0) begin
        check_output("rr_first_rvalid0_a", rvalid0_a, 8'h0);
        check_output("rr_first_rvalid1_a", rvalid1_a, 8'h0);
      end else begin
        check_output("rr_rvalid0_a", rvalid0_a, {7'b0, ~ids[i-1]});
        check_output("rr_rvalid1_a", rvalid1_a, {7'b0, ids[i-1]});
        check_output("rr_rdata_a", rdata_a, rom_fn(t3_addr(ids[i-1])));
      end
      if (i >= 2) begin
        check_output("rr_rvalid0_b", rvalid0_b, {7'b0, ~ids[i-2]});
        check_output("rr_rvalid1_b", rvalid1_b, {7'b0, ids[i-2]});
        check_output("rr_rdata_b", rdata_b, rom_fn(t3_addr(ids[i-2])));
      end
    end
    apply_stimulus(1'b0, 8'h10, 1'b0, 8'h20);
    check_output("rr_idle_gnt0_a", gnt0_a, 8'h0);
    check_output("rr_held_addr_a", rom_addr_a, t3_addr(ids[5]));
    check_output("rr_tail_rvalid1_a", rvalid1_a, {7'b0, ids[5]});
    check_output("rr_tail_rdata_a", rdata_a, rom_fn(t3_addr(ids[5])));
    check_output("rr_tail_rvalid0_b", rvalid0_b, {7'b0, ~ids[4]});
    check_output("rr_tail_rdata_b", rdata_b, rom_fn(t3_addr(ids[4])));
    apply_stimulus(1'b0, 8'h10, 1'b0, 8'h20);
    check_output("rr_tail2_busy_a", busy_a, 8'h0);
    check_output("rr_tail2_rvalid1_a", rvalid1_a, 8'h0);
    check_output("rr_tail2_rvalid1_b", rvalid1_b, {7'b0, ids[5]});
    check_output("rr_tail2_rdata_b", rdata_b, rom_fn(t3_addr(ids[5])));
    check_output("rr_tail2_busy_b", busy_b, 8'h1);
    apply_stimulus(1'b0, 8'h10, 1'b0, 8'h20);
    check_output("rr_drain_busy_b", busy_b, 8'h0);
    $display("[TB] tie-break checks done");

    // Single read from requester 0 at address 05.
    apply_stimulus(1'b1, 8'h05, 1'b0, 8'h00);
    check_output("one_gnt0_a", gnt0_a, 8'h1);
    check_output("one_gnt1_a", gnt1_a, 8'h0);
    check_output("one_rom_addr_a", rom_addr_a, 8'h05);
    check_output("one_rom_addr_b", rom_addr_b, 8'h05);
    apply_stimulus(1'b0, 8'h05, 1'b0, 8'h00);
    check_output("one_rvalid0_a", rvalid0_a, 8'h1);
    check_output("one_rvalid1_a", rvalid1_a, 8'h0);
    check_output("one_rdata_a", rdata_a, rom_fn(8'h05));
    check_output("one_early_rvalid0_b", rvalid0_b, 8'h0);
    check_output("one_busy_b", busy_b, 8'h1);
    check_output("one_idle_gnt0_a", gnt0_a, 8'h0);
    check_output("one_held_addr_a", rom_addr_a, 8'h05);
    apply_stimulus(1'b0, 8'h05, 1'b0, 8'h00);
    check_output("one_done_rvalid0_a", rvalid0_a, 8'h0);
    check_output("one_done_busy_a", busy_a, 8'h0);
    check_output("one_rvalid0_b", rvalid0_b, 8'h1);
    check_output("one_rvalid1_b", rvalid1_b, 8'h0);
    check_output("one_rdata_b", rdata_b, rom_fn(8'h05));
    check_output("one_late_busy_b", busy_b, 8'h1);
    apply_stimulus(1'b0, 8'h05, 1'b0, 8'h00);
    check_output("one_drain_busy_b", busy_b, 8'h0);
    $display("[TB] single-read checks done");

    // Requester 1 burst over addresses 00..03, observed on the latency-2 instance.
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1'b0, 8'h00, 1'b1, 8'(k));
      check_output("burst_gnt1_b", gnt1_b, 8'h1);
      check_output("burst_gnt0_b", gnt0_b, 8'h0);
      check_output("burst_rom_addr_b", rom_addr_b, 8'(k));
      if (k >= 1) check_output("burst_busy_b", busy_b, 8'h1);
      if (k >= 2) begin
        check_output("burst_rvalid1_b", rvalid1_b, 8'h1);
        check_output("burst_rdata_b", rdata_b, rom_fn(8'(k - 2)));
      end
    end
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h03);
    check_output("burst_t1_rvalid1_b", rvalid1_b, 8'h1);
    check_output("burst_t1_rdata_b", rdata_b, rom_fn(8'h02));
    check_output("burst_t1_busy_b", busy_b, 8'h1);
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h03);
    check_output("burst_t2_rvalid1_b", rvalid1_b, 8'h1);
    check_output("burst_t2_rdata_b", rdata_b, rom_fn(8'h03));
    check_output("burst_t2_busy_b", busy_b, 8'h1);
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h03);
    check_output("burst_end_busy_b", busy_b, 8'h0);
    check_output("burst_end_rvalid1_b", rvalid1_b, 8'h0);
    $display("[TB] burst checks done");

    // Reset one cycle after a requester-0 handshake: no strobe, pointer back to favour requester 0.
    apply_stimulus(1'b1, 8'h33, 1'b0, 8'h00);
    check_output("mid_gnt0_a", gnt0_a, 8'h1);
    @(negedge sys_clk);
    req0 = 1'b0;
    sys_rst = 1'b1;
    #1;
    check_output("mid_busy_a", busy_a, 8'h0);
    check_output("mid_rvalid0_a", rvalid0_a, 8'h0);
    check_output("mid_busy_b", busy_b, 8'h0);
    check_output("mid_rvalid0_b", rvalid0_b, 8'h0);
    check_output("mid_rom_addr_b", rom_addr_b, 8'h00);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    #1;
    check_output("mid_after_rvalid0_b", rvalid0_b, 8'h0);
    check_output("mid_after_busy_b", busy_b, 8'h0);
    apply_stimulus(1'b1, 8'h10, 1'b1, 8'h20);
    check_output("mid_tie_gnt0_a", gnt0_a, 8'h1);
    check_output("mid_tie_gnt1_a", gnt1_a, 8'h0);
    check_output("mid_tie_gnt0_b", gnt0_b, 8'h1);
    apply_stimulus(1'b0, 8'h00, 1'b0, 8'h00);
    $display("[TB] mid-read reset checks done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
